// File: rtl/echo_corr_pkg.sv
// Shared widths, defaults and FSM encoding for the echo_correlator block.
// Also holds the abs/saturate helper used by the correlator datapath.
package echo_corr_pkg;

  localparam int ADC_W  = 12;
  localparam int CORR_W = 18;
  localparam int TOF_W  = 20;
  localparam int ACC_W  = 20;

  localparam int          DEF_TAPS        = 16;
  localparam logic [63:0] DEF_TEMPLATE    = 64'h0000_0000_0000_F0F0;
  localparam int          DEF_ADC_MID     = 2048;
  localparam int          DEF_NUM_SAMPLES = 20000;

  localparam logic [CORR_W-1:0] CORR_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One extra bit keeps the negation of the most negative sum representable.
  function automatic logic [CORR_W-1:0] abs_sat(input logic signed [ACC_W-1:0] acc);
    logic [ACC_W:0] ext;
    logic [ACC_W:0] mag;
    ext = {acc[ACC_W-1], acc};
    mag = acc[ACC_W-1] ? (~ext + 1'b1) : ext;
    if (mag > {{(ACC_W+1-CORR_W){1'b0}}, CORR_MAX})
      abs_sat = CORR_MAX;
    else
      abs_sat = mag[CORR_W-1:0];
  endfunction

endpackage

// File: rtl/echo_corr_mac.sv
// Delay line of midscale-removed samples, +/-1 template adder tree, and a
// registered absolute value saturated to CORR_W bits.
module echo_corr_mac
  import echo_corr_pkg::*;
#(
  parameter int          TAPS     = DEF_TAPS,
  parameter logic [63:0] TEMPLATE = DEF_TEMPLATE,
  parameter int          ADC_MID  = DEF_ADC_MID
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              sample_valid,
  input  logic [ADC_W-1:0]  sample_data,
  output logic [CORR_W-1:0] corr,
  output logic              corr_valid,
  output logic              window_full
);

  localparam int FILL_W = $clog2(TAPS + 1);
  localparam logic signed [ADC_W:0] MID = (ADC_W+1)'(ADC_MID);

  logic signed [ADC_W:0]   tap_reg [TAPS];
  logic signed [ACC_W-1:0] term    [TAPS];
  logic signed [ACC_W-1:0] acc;
  logic signed [ADC_W:0]   d_in;
  logic [FILL_W-1:0]       fill_reg;
  logic                    shift_reg;
  logic [CORR_W-1:0]       corr_reg;
  logic                    corr_valid_reg;

  assign d_in = $signed({1'b0, sample_data}) - MID;

  // Tap 0 always holds the newest sample; only real samples shift the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) tap_reg[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < TAPS; i++) tap_reg[i] <= '0;
    end else if (sample_valid) begin
      tap_reg[0] <= d_in;
      for (int i = 1; i < TAPS; i++) tap_reg[i] <= tap_reg[i-1];
    end
  end

  generate
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_term
      assign term[gi] = TEMPLATE[gi] ? ACC_W'(tap_reg[gi]) : -ACC_W'(tap_reg[gi]);
    end
  endgenerate

  always_comb begin
    acc = '0;
    for (int i = 0; i < TAPS; i++) acc = acc + term[i];
  end

  assign window_full = (fill_reg == FILL_W'(TAPS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_reg       <= '0;
      shift_reg      <= 1'b0;
      corr_reg       <= '0;
      corr_valid_reg <= 1'b0;
    end else if (clear) begin
      fill_reg       <= '0;
      shift_reg      <= 1'b0;
      corr_reg       <= '0;
      corr_valid_reg <= 1'b0;
    end else begin
      shift_reg <= sample_valid;
      if (sample_valid && !window_full)
        fill_reg <= fill_reg + 1'b1;
      // Windows that are not yet full never produce a valid correlation.
      corr_valid_reg <= shift_reg && window_full;
      if (shift_reg)
        corr_reg <= abs_sat(acc);
    end
  end

  assign corr       = corr_reg;
  assign corr_valid = corr_valid_reg;

endmodule

// File: rtl/echo_correlator.sv
// Pulse-echo matched-filter detector: FIFO reader FSM, sample indexing and
// peak/time-of-flight tracking. Define ECHO_CORR_FIRST_HIT_EN for first-arrival mode.
module echo_correlator
  import echo_corr_pkg::*;
#(
  parameter int          TAPS        = DEF_TAPS,
  parameter logic [63:0] TEMPLATE    = DEF_TEMPLATE,
  parameter int          NUM_SAMPLES = DEF_NUM_SAMPLES,
  parameter int          ADC_MID     = DEF_ADC_MID
) (
  input  logic              clk_50M,
  input  logic              rst,
  input  logic              sys_start_pulse,
  input  logic [ADC_W-1:0]  fifo_q,
  input  logic              fifo_empty,
  output logic              fifo_rdreq,
  input  logic [CORR_W-1:0] corr_threshold,
  output logic [TOF_W-1:0]  echo_tof,
  output logic [CORR_W-1:0] echo_peak,
  output logic              hit_flag,
  output logic              processing_done
);

  localparam int RD_W = $clog2(NUM_SAMPLES + 1);
  localparam logic [RD_W-1:0] RD_TOTAL = RD_W'(NUM_SAMPLES);
  localparam logic [RD_W-1:0] RD_LAST  = RD_W'(NUM_SAMPLES - 1);

  state_t state_reg, state_next;

  logic [RD_W-1:0]   issued_reg;
  logic              rd_pending_reg;
  logic              cap_valid_reg;
  logic [TOF_W-1:0]  sample_cnt_reg;
  logic [TOF_W-1:0]  cap_idx_reg;
  logic [TOF_W-1:0]  corr_idx_reg;
  logic [CORR_W-1:0] peak_reg;
  logic [TOF_W-1:0]  tof_reg;
  logic              hit_reg;
  logic              rdreq;
  logic              pipe_busy;
  logic              update;

  logic [CORR_W-1:0] corr;
  logic              corr_valid;
  logic              window_full;

`ifdef ECHO_CORR_FIRST_HIT_EN
  logic [CORR_W-1:0] prev_corr_reg;
  logic              frozen_reg;
  logic              freeze;
`endif

  echo_corr_mac #(
    .TAPS     (TAPS),
    .TEMPLATE (TEMPLATE),
    .ADC_MID  (ADC_MID)
  ) u_mac (
    .clk          (clk_50M),
    .rst          (rst),
    .clear        (sys_start_pulse),
    .sample_valid (rd_pending_reg),
    .sample_data  (fifo_q),
    .corr         (corr),
    .corr_valid   (corr_valid),
    .window_full  (window_full)
  );

  assign pipe_busy = rd_pending_reg || cap_valid_reg || corr_valid;

  // A start pulse wins over everything and suppresses the read in its own cycle.
  always_comb begin
    state_next = state_reg;
    rdreq      = 1'b0;
    if (sys_start_pulse) begin
      state_next = RUN;
    end else begin
      case (state_reg)
        IDLE: state_next = IDLE;
        RUN: begin
          rdreq = !fifo_empty && (issued_reg < RD_TOTAL);
          if (rdreq && (issued_reg == RD_LAST))
            state_next = DRAIN;
        end
        DRAIN: begin
          if (!pipe_busy)
            state_next = DONE;
        end
        DONE: state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    update = 1'b0;
`ifdef ECHO_CORR_FIRST_HIT_EN
    freeze = 1'b0;
    if (corr_valid && window_full) begin
      if (!hit_reg) begin
        update = (corr > corr_threshold) && (corr > peak_reg);
      end else if (!frozen_reg) begin
        // Stop at the first non-rising sample after the hit: first local maximum.
        if (corr > prev_corr_reg)
          update = 1'b1;
        else
          freeze = 1'b1;
      end
    end
`else
    update = corr_valid && window_full && (corr > corr_threshold) && (corr > peak_reg);
`endif
  end

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      issued_reg     <= '0;
      rd_pending_reg <= 1'b0;
      cap_valid_reg  <= 1'b0;
      sample_cnt_reg <= '0;
      cap_idx_reg    <= '0;
      corr_idx_reg   <= '0;
      peak_reg       <= '0;
      tof_reg        <= '0;
      hit_reg        <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (sys_start_pulse) begin
        // Any read still in flight is dropped; the FIFO itself is left alone.
        issued_reg     <= '0;
        rd_pending_reg <= 1'b0;
        cap_valid_reg  <= 1'b0;
        sample_cnt_reg <= '0;
        cap_idx_reg    <= '0;
        corr_idx_reg   <= '0;
        peak_reg       <= '0;
        tof_reg        <= '0;
        hit_reg        <= 1'b0;
      end else begin
        rd_pending_reg <= rdreq;
        if (rdreq)
          issued_reg <= issued_reg + 1'b1;
        cap_valid_reg <= rd_pending_reg;
        if (rd_pending_reg) begin
          cap_idx_reg    <= sample_cnt_reg;
          sample_cnt_reg <= sample_cnt_reg + 1'b1;
        end
        if (cap_valid_reg)
          corr_idx_reg <= cap_idx_reg;
        if (update) begin
          peak_reg <= corr;
          tof_reg  <= corr_idx_reg;
          hit_reg  <= 1'b1;
        end
      end
    end
  end

`ifdef ECHO_CORR_FIRST_HIT_EN
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      prev_corr_reg <= '0;
      frozen_reg    <= 1'b0;
    end else if (sys_start_pulse) begin
      prev_corr_reg <= '0;
      frozen_reg    <= 1'b0;
    end else begin
      if (corr_valid)
        prev_corr_reg <= corr;
      if (freeze)
        frozen_reg <= 1'b1;
    end
  end
`endif

  assign fifo_rdreq      = rdreq;
  assign echo_tof        = tof_reg;
  assign echo_peak       = peak_reg;
  assign hit_flag        = hit_reg;
  assign processing_done = (state_reg == DONE);

endmodule

// File: tb/tb_echo_correlator.sv
// Directed bench for echo_correlator: a rate-limited FIFO model feeds sample
// tables; expected end-of-run results are queued at start and checked at done.
`timescale 1ns/1ps
module tb_echo_correlator;

  localparam int N   = 1100;
  localparam int THR = 4500;

  logic        clk_50M = 1'b0;
  logic        rst = 1'b1;
  logic        sys_start_pulse = 1'b0;
  logic [11:0] fifo_q = '0;
  logic        fifo_empty;
  logic        fifo_rdreq;
  logic [17:0] corr_threshold = 18'(THR);
  logic [19:0] echo_tof;
  logic [17:0] echo_peak;
  logic        hit_flag;
  logic        processing_done;

  always #10 clk_50M = ~clk_50M;

  echo_correlator #(
    .TAPS        (16),
    .TEMPLATE    (64'hF0F0),
    .NUM_SAMPLES (N),
    .ADC_MID     (2048)
  ) dut (
    .clk_50M         (clk_50M),
    .rst             (rst),
    .sys_start_pulse (sys_start_pulse),
    .fifo_q          (fifo_q),
    .fifo_empty      (fifo_empty),
    .fifo_rdreq      (fifo_rdreq),
    .corr_threshold  (corr_threshold),
    .echo_tof        (echo_tof),
    .echo_peak       (echo_peak),
    .hit_flag        (hit_flag),
    .processing_done (processing_done)
  );

  // FIFO model: normal mode, q valid one clock after rdreq, 0..3 idle clocks per write.
  int samples [N];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int gap_cnt = 0;
  int underflows = 0;
  bit flush = 1'b1;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk_50M) begin
    if (flush) begin
      wr_ptr  <= 0;
      rd_ptr  <= 0;
      gap_cnt <= 0;
    end else begin
      if (fifo_rdreq && fifo_empty) underflows <= underflows + 1;
      if (fifo_rdreq && !fifo_empty) begin
        fifo_q <= 12'(samples[rd_ptr]);
        rd_ptr <= rd_ptr + 1;
      end
      if (gap_cnt == 0) begin
        if (wr_ptr < N) wr_ptr <= wr_ptr + 1;
        gap_cnt <= int'($urandom_range(3, 0));
      end else begin
        gap_cnt <= gap_cnt - 1;
      end
    end
  end

  typedef struct {
    string tag;
    int    peak;
    int    tof;
    bit    hit;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int fails  = 0;
  logic [15:0] tmpl = 16'hF0F0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill_mid();
    for (int i = 0; i < N; i++) samples[i] = 2048;
  endtask

  task automatic add_burst(input int last, input int amp);
    for (int k = 0; k < 16; k++) samples[last-k] = tmpl[k] ? 2048 + amp : 2048 - amp;
  endtask

  task automatic pulse_start();
    @(negedge clk_50M);
    flush = 1'b1;
    sys_start_pulse = 1'b1;
    @(negedge clk_50M);
    flush = 1'b0;
    sys_start_pulse = 1'b0;
  endtask

  task automatic start_run(input string tag, input int peak, input int tof, input bit hit);
    exp_t e;
    e.tag = tag; e.peak = peak; e.tof = tof; e.hit = hit;
    sb.push_back(e);
    pulse_start();
  endtask

  task automatic wait_rd(input int target, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk_50M);
      if (rd_ptr > target) begin ok = 1'b1; break; end
    end
    check({tag, "_reached"}, 32'(ok), 32'd1);
  endtask

  task automatic finish_run();
    exp_t e;
    bit ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk_50M);
      if (processing_done) begin ok = 1'b1; break; end
    end
    e = sb.pop_front();
    check({e.tag, "_done"}, 32'(ok), 32'd1);
    check({e.tag, "_peak"}, 32'(echo_peak), 32'(e.peak));
    check({e.tag, "_tof"},  32'(echo_tof),  32'(e.tof));
    check({e.tag, "_hit"},  32'(hit_flag),  32'(e.hit));
    repeat (5) @(negedge clk_50M);
    check({e.tag, "_reads"}, 32'(rd_ptr), 32'(N));
    check({e.tag, "_done_sticky"}, 32'(processing_done), 32'd1);
    $display("run %s: peak=%0d tof=%0d hit=%0d done=%0d", e.tag, echo_peak, echo_tof, hit_flag, processing_done);
  endtask

  initial begin
    int held;
    fill_mid();
    repeat (3) @(negedge clk_50M);
    check("rst_tof",   32'(echo_tof), 32'd0);
    check("rst_peak",  32'(echo_peak), 32'd0);
    check("rst_hit",   32'(hit_flag), 32'd0);
    check("rst_done",  32'(processing_done), 32'd0);
    check("rst_rdreq", 32'(fifo_rdreq), 32'd0);
    rst = 1'b0;
    flush = 1'b0;
    repeat (10) @(negedge clk_50M);
    check("idle_no_reads", 32'(rd_ptr), 32'd0);

    // Flat midscale input never correlates.
    fill_mid();
    start_run("flat", 0, 0, 1'b0);
    check("start_done_clear", 32'(processing_done), 32'd0);
    finish_run();

    // Single burst, plus output latency after the fetch of its last sample.
    fill_mid(); add_burst(1015, 300);
    start_run("burst300", 4800, 1015, 1'b1);
    wait_rd(1015, "lat_fetch");
    repeat (4) @(negedge clk_50M);
    check("lat_tof",  32'(echo_tof), 32'd1015);
    check("lat_peak", 32'(echo_peak), 32'd4800);
    finish_run();

    fill_mid(); add_burst(1015, 250);
    start_run("burst250", 0, 0, 1'b0);
    finish_run();

    fill_mid(); add_burst(415, 300); add_burst(1015, 400);
`ifdef ECHO_CORR_FIRST_HIT_EN
    start_run("two_bursts", 4800, 415, 1'b1);
`else
    start_run("two_bursts", 6400, 1015, 1'b1);
`endif
    finish_run();

    // Threshold 0: first nonzero full window (sample 20) wins; equal later values do not move it.
    corr_threshold = 18'd0;
    fill_mid(); samples[20] = 2049;
    start_run("thr_zero", 1, 20, 1'b1);
    finish_run();

    corr_threshold = 18'h3FFFF;
    fill_mid(); add_burst(415, 2047);
    start_run("thr_max", 0, 0, 1'b0);
    finish_run();
    corr_threshold = 18'(THR);

    // Async reset mid-run, then a clean rerun.
    fill_mid(); add_burst(415, 300);
    pulse_start();
    wait_rd(700, "pre_reset");
    check("pre_reset_hit", 32'(hit_flag), 32'd1);
    @(negedge clk_50M);
    rst = 1'b1;
    #1;
    check("async_rst_peak", 32'(echo_peak), 32'd0);
    check("async_rst_tof",  32'(echo_tof), 32'd0);
    check("async_rst_hit",  32'(hit_flag), 32'd0);
    check("async_rst_rdreq", 32'(fifo_rdreq), 32'd0);
    @(negedge clk_50M);
    rst = 1'b0;
    held = rd_ptr;
    repeat (5) @(negedge clk_50M);
    check("post_rst_idle", 32'(rd_ptr), 32'(held));
    fill_mid(); add_burst(1015, 300);
    start_run("after_reset", 4800, 1015, 1'b1);
    finish_run();

    // Restart during RUN: outputs clear at once and the sample index restarts at 0.
    fill_mid(); add_burst(415, 300);
    pulse_start();
    wait_rd(600, "pre_restart");
    check("pre_restart_peak", 32'(echo_peak), 32'd4800);
    fill_mid(); add_burst(1015, 300);
    start_run("restart", 4800, 1015, 1'b1);
    check("restart_peak_clr", 32'(echo_peak), 32'd0);
    check("restart_tof_clr",  32'(echo_tof), 32'd0);
    check("restart_hit_clr",  32'(hit_flag), 32'd0);
    finish_run();

    check("no_underflow", 32'(underflows), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #(20ns * 200000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/echo_correlator.md
Name: echo_correlator

Overview:
- Pulse-echo matched-filter detector in the ultrasound receive path.
- Pulls 12-bit ADC samples from an upstream dual-clock FIFO in normal (non-show-ahead) mode, where q is valid one clock after rdreq.
- Correlates the sample stream against a fixed ±1 transmit template.
- Reports the strongest above-threshold correlation and its sample index as the time of flight.

Parameters:
- TAPS, 16: template length in samples; legal range 4..64.
- TEMPLATE, 16'hF0F0: coefficient bits, bit k for tap k (k=0 is the newest sample); 1 means +1, 0 means -1.
- NUM_SAMPLES, 20000: samples consumed per acquisition.
- ADC_MID, 2048: offset-binary midscale, subtracted from every sample.

Ports:
- clk_50M, in, 1: system clock.
- rst, in, 1: asynchronous active-high reset.
- sys_start_pulse, in, 1: one-cycle acquisition start.
- fifo_q, in, 12: FIFO read data.
- fifo_empty, in, 1: FIFO read-side empty flag.
- fifo_rdreq, out, 1: FIFO read request.
- corr_threshold, in, 18: unsigned detection threshold.
- echo_tof, out, 20: sample index at the recorded peak.
- echo_peak, out, 18: recorded peak correlation magnitude.
- hit_flag, out, 1: at least one sample has exceeded the threshold.
- processing_done, out, 1: acquisition complete (sticky).

Behaviour:
- Reset (async, rst=1): all outputs 0, state IDLE, delay line, counters and pipeline cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - fifo_rdreq=0.
  - sys_start_pulse moves to RUN and clears echo_tof, echo_peak, hit_flag, processing_done, sample counter and delay line.
- RUN:
  - fifo_rdreq = ~fifo_empty, and low once NUM_SAMPLES reads have been issued.
  - fifo_q is captured the cycle after each accepted rdreq as sample n (0-based) and shifted into a TAPS-deep delay line.
- DRAIN: entered after the last read is issued; waits until the pipeline is empty.
- DONE: processing_done=1; no further reads.
- sys_start_pulse in any state restarts exactly as from IDLE. In-flight data is discarded and FIFO contents are not flushed.
- Datapath:
  - d = fifo_q - ADC_MID, signed 13-bit.
  - corr = |Σ c_k·d[n-k]|, with 20-bit signed accumulation.
  - corr magnitude saturates to 18 bits (262143).
  - corr is registered one cycle after the sample is captured.
- Evaluation is suppressed until the window is full, i.e. n ≥ TAPS-1.
- Detection, evaluated in the cycle after corr is registered: if corr > corr_threshold (strict) and corr > echo_peak, then:
  - echo_peak = corr;
  - echo_tof = n, the newest sample in the window;
  - hit_flag = 1.
- Equal-value later peaks do not move echo_tof.
- Latency: outputs reflect sample n no later than 4 clocks after the rdreq edge that fetched it.
- Boundaries:
  - FIFO empty mid-run simply stalls the pipeline; no bubble enters the delay line.
  - echo_tof counter is 20 bits and wrap is impossible for NUM_SAMPLES ≤ 2^20.
  - A threshold of 0 hits on the first nonzero full-window corr.
  - A threshold of 262143 never hits.

Optional Feature:
- ECHO_CORR_FIRST_HIT_EN defined (first-arrival mode):
  - After hit_flag rises, echo_peak and echo_tof keep tracking only while corr is still rising.
  - They freeze at the first sample where corr does not exceed the previous corr, capturing the first local maximum above threshold.
- Undefined: global maximum over the whole acquisition, as described under Behaviour.

Decomposition:
- Package echo_corr_pkg holds:
  - ADC_W=12, CORR_W=18, TOF_W=20, ACC_W=20;
  - default TAPS, TEMPLATE and ADC_MID;
  - the FSM state enum.
- Sub-module echo_corr_mac: delay line plus ±1 adder tree, abs and saturate.
  - Inputs: sample valid/data, clear.
  - Outputs: corr, corr_valid, window_full.
- The top level holds the FSM, FIFO handshake, counter and peak tracker.
- fifo is the existing IP and sits outside this block.

Test Plan:
All scenarios use TAPS=16, TEMPLATE=16'hF0F0, threshold 4500, and a FIFO written at 1 sample per 50 clocks.
- All 20000 samples = 2048: processing_done=1 after the last sample, hit_flag=0, echo_peak=0, echo_tof=0.
- Template burst of amplitude 300 (2348/1748) ending at sample 1015, rest 2048: corr=4800, hit_flag=1, echo_peak=4800, echo_tof=1015.
- Same burst at amplitude 250: corr 4000 ≤ 4500, so hit_flag=0, echo_peak=0.
- Bursts at amplitude 300 ending at 1015 and amplitude 400 ending at 5015:
  - default build: echo_peak=6400, echo_tof=5015;
  - with ECHO_CORR_FIRST_HIT_EN: echo_peak=4800, echo_tof=1015.
- Assert rst at sample 3000, then issue a new start: all outputs 0 immediately; the second run reproduces the expected single-burst results.
- sys_start_pulse during RUN: peak, tof and flags clear within 1 cycle; the sample index restarts at 0.
